// File: rtl/pim_pkg.sv
// Shared constants and helpers for the PIM crossbar datapath.
// The lane-select macro keeps lane 0 in the most significant slot of a packed bus.
`ifndef PIM_PKG_MACROS
`define PIM_PKG_MACROS
`define PIM_LANE(bus, lanes, w, l) bus[((lanes) - 1 - (l)) * (w) +: (w)]
`endif

package pim_pkg;

    localparam int DEF_LANES = 3;
    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pim_psum_accum_sat_lane.sv
// Signed clamp from the wide accumulator width down to the output lane width.
// Also reports whether the value had to be clamped.
module pim_sat_lane #(
    parameter int ACC_W = 11,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    generate
        if (ACC_W > OUT_W) begin : g_clamp
            logic [ACC_W-OUT_W:0] upper;

            // The value fits only when every bit above the output sign bit matches it.
            assign upper = acc[ACC_W-1:OUT_W-1];

            always_comb begin
                result = acc[OUT_W-1:0];
                sat    = 1'b0;
                if (!(&upper) && (|upper)) begin
                    sat    = 1'b1;
                    result = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_extend
            assign result = OUT_W'(acc);
            assign sat    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pim_psum_accum.sv
// Shift-add accumulator for packed crossbar partial sums.
// Emits one saturated packed result per BEATS accepted beats over valid/ready.
module pim_psum_accum
    import pim_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int BEATS      = 4,
    parameter int SHIFT_STEP = 0,
    parameter bit MSB_NEG    = 1'b0,
    localparam int IDX_W     = (BEATS > 1) ? clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_psum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [IDX_W-1:0]       beat_idx
);

    localparam int ACC_W = IN_W + SHIFT_STEP * (BEATS - 1) + clog2(BEATS) + 1;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]             state;
    logic                   accept;
    logic                   final_beat;
    logic [LANES*OUT_W-1:0] sat_data;
    logic [LANES-1:0]       sat_flag;

    assign out_valid  = (state == ST_FULL);
    assign in_ready   = !(out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_idx == IDX_W'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [IN_W-1:0]  psum;
        logic signed [ACC_W-1:0] term;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] acc_next;
        logic signed [OUT_W-1:0] lane_result;

        assign psum     = `PIM_LANE(in_psum, LANES, IN_W, l);
        assign term     = ACC_W'(psum) <<< (beat_idx * SHIFT_STEP);
        // With MSB_NEG the last beat carries the two's-complement sign slice.
        assign acc_next = (MSB_NEG && final_beat) ? acc - term : acc + term;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (accept) begin
                acc <= final_beat ? '0 : acc_next;
            end
        end

        pim_sat_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_sat (
            .acc    (acc_next),
            .result (lane_result),
            .sat    (sat_flag[l])
        );

        assign `PIM_LANE(sat_data, LANES, OUT_W, l) = lane_result;
    end

    // A final beat reloads the output register even while a handshake drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACC;
            beat_idx <= '0;
            out_data <= '0;
            out_sat  <= '0;
        end else begin
            if (accept) begin
                beat_idx <= final_beat ? '0 : beat_idx + 1'b1;
            end
            if (accept && final_beat) begin
                state    <= ST_FULL;
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end else if (out_ready) begin
                state <= ST_ACC;
            end
        end
    end

endmodule
